// File: rtl/axi_read_arbiter.sv
// One-outstanding AXI4-Lite read arbiter: N requesters share a single AR/R channel to one slave.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default is fixed priority, index 0 highest).
module axi_read_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [N_MASTERS-1:0]          m_arvalid,
  output logic [N_MASTERS-1:0]          m_arready,
  output logic [31:0]                   m_rdata,
  output logic [1:0]                    m_rresp,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [31:0]                   s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rvalid,
  output logic                          s_rready
);

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_grant;
  logic [IDX_W-1:0]      r_last;
  logic [ADDR_W-1:0]     r_s_araddr;
  logic                  r_s_arvalid;
  logic [N_MASTERS-1:0]  r_m_arready;

  logic [IDX_W-1:0]      w_win;
  logic [ADDR_W-1:0]     w_win_addr;
  logic [IDX_W-1:0]      w_last_nxt;
  logic                  w_req;
  logic                  w_in_data;
  logic                  w_r_hs;

  assign w_req = |m_arvalid;

`ifdef ARB_ROUND_ROBIN_EN
  logic w_found;

  // Search upward from the master after the last one served, wrapping around.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (!w_found && m_arvalid[IDX_W'((32'(r_last) + 32'd1 + k) % N_MASTERS)]) begin
        w_win   = IDX_W'((32'(r_last) + 32'd1 + k) % N_MASTERS);
        w_found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scan from the top so the lowest requesting index wins.
  always_comb begin
    w_win = '0;
    for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
      if (m_arvalid[i]) w_win = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    w_win_addr = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (w_win == IDX_W'(i)) w_win_addr = m_araddr[i*ADDR_W +: ADDR_W];
    end
  end

  // Response path is pure routing to the granted master while in DATA.
  assign w_in_data = (r_state == DATA);
  assign s_rready  = w_in_data & m_rready[r_grant];
  assign m_rvalid  = (w_in_data && s_rvalid) ? (N_MASTERS'(1) << r_grant) : '0;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign w_r_hs    = s_rvalid & s_rready;

  assign w_last_nxt = (w_in_data && w_r_hs) ? r_grant : r_last;

  assign s_araddr  = r_s_araddr;
  assign s_arvalid = r_s_arvalid;
  assign m_arready = r_m_arready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_last      <= IDX_W'(N_MASTERS - 1);
      r_s_araddr  <= '0;
      r_s_arvalid <= 1'b0;
      r_m_arready <= '0;
    end else begin
      r_last <= w_last_nxt;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_grant     <= w_win;
            r_s_araddr  <= w_win_addr;
            r_s_arvalid <= 1'b1;
            r_m_arready <= N_MASTERS'(1) << w_win;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          r_m_arready <= '0;
          if (s_arready) begin
            r_s_arvalid <= 1'b0;
            r_state     <= DATA;
          end
        end
        DATA: begin
          if (w_r_hs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: directed master/slave traffic, monitor checks grants and routed responses.
module tb_axi_read_arbiter;

  typedef struct {
    int          idx;
    logic [31:0] val;
    logic [1:0]  resp;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [63:0] m_araddr;
  logic [1:0]  m_arvalid;
  logic [1:0]  m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;

  exp_t        g_q[$];
  exp_t        r_q[$];
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  int          ar_delay;
  int          r_delay;
  int          n_tests;
  int          n_fail;

  axi_read_arbiter #(.N_MASTERS(2), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] onehot(input int idx);
    logic [1:0] one;
    one = 2'b01;
    return one << idx;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  task automatic push_g(input int idx, input logic [31:0] a);
    exp_t e;
    e.idx = idx; e.val = a; e.resp = 2'b00;
    g_q.push_back(e);
  endtask

  task automatic push_r(input int idx, input logic [31:0] d, input logic [1:0] rr);
    exp_t e;
    e.idx = idx; e.val = d; e.resp = rr;
    r_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((g_q.size() != 0 || r_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (g_q.size() != 0 || r_q.size() != 0) fail_now(name, 64'(g_q.size() + r_q.size()));
  endtask

  task automatic wait_rv(input int idx, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_rvalid[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_rvalid[idx]) fail_now(name, 64'(m_rvalid));
  endtask

  // Master agents: hold each queued address valid until its arready handshake.
  initial begin : masters
    logic [1:0] hs;
    m_arvalid = 2'b00;
    m_araddr  = '0;
    forever begin
      @(negedge clk);
      hs = m_arvalid & m_arready;
      @(posedge clk); #1;
      if (hs[0] && mq0.size() > 0) begin void'(mq0.pop_front()); m_arvalid[0] = 1'b0; end
      if (hs[1] && mq1.size() > 0) begin void'(mq1.pop_front()); m_arvalid[1] = 1'b0; end
      if (!m_arvalid[0] && mq0.size() > 0) begin m_araddr[31:0]  = mq0[0]; m_arvalid[0] = 1'b1; end
      if (!m_arvalid[1] && mq1.size() > 0) begin m_araddr[63:32] = mq1[0]; m_arvalid[1] = 1'b1; end
    end
  end

  // Slave model: data = addr ^ 0xFFFF0000 (0x1000 returns 0xDEADBEEF), resp = addr[3:2].
  initial begin : slave
    logic [31:0] a;
    logic        hs;
    logic        abort;
    int          n;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    forever begin
      @(posedge clk); #1;
      if (rstn && s_arvalid) begin
        repeat (ar_delay) begin @(posedge clk); #1; end
        a = s_araddr;
        s_arready = 1'b1;
        @(posedge clk); #1;
        s_arready = 1'b0;
        repeat (r_delay) begin @(posedge clk); #1; end
        s_rdata  = (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'hFFFF_0000);
        s_rresp  = a[3:2];
        s_rvalid = 1'b1;
        hs = 1'b0; abort = 1'b0; n = 0;
        while (!hs && !abort && n < 1000) begin
          @(negedge clk);
          abort = !rstn;
          hs    = s_rready && rstn;
          if (!abort) begin @(posedge clk); #1; end
          n++;
        end
        s_rvalid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every grant pulse and every response handshake.
  initial begin : monitor
    exp_t        e;
    logic        prev_v;
    logic [31:0] prev_a;
    prev_v = 1'b0; prev_a = '0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (m_arready != 2'b00) begin
          if (g_q.size() == 0) fail_now("unexpected_arready", 64'(m_arready));
          else begin
            e = g_q.pop_front();
            chk("arready_grant", 64'(m_arready), 64'(onehot(e.idx)));
            chk("s_araddr_at_grant", 64'(s_araddr), 64'(e.val));
            chk("s_arvalid_at_grant", 64'(s_arvalid), 64'd1);
          end
        end
        if (s_arvalid && prev_v) chk("s_araddr_stable", 64'(s_araddr), 64'(prev_a));
        if (m_rvalid != 2'b00) begin
          if (r_q.size() == 0) fail_now("unexpected_rvalid", 64'(m_rvalid));
          else begin
            chk("rvalid_route", 64'(m_rvalid), 64'(onehot(r_q[0].idx)));
            if ((m_rvalid & m_rready) != 2'b00) begin
              e = r_q.pop_front();
              chk("rdata", 64'(m_rdata), 64'(e.val));
              chk("rresp", 64'(m_rresp), 64'(e.resp));
              chk("s_rready_at_hs", 64'(s_rready), 64'd1);
            end
          end
        end
        prev_v = s_arvalid;
        prev_a = s_araddr;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          t2_idx[6];
    logic [31:0] t2_addr[6];
    logic [31:0] t2_data[6];
    logic [1:0]  t2_resp[6];
    n_tests = 0; n_fail = 0;
    ar_delay = 0; r_delay = 0;
    rstn = 1'b0;
    m_rready = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
    t2_idx  = '{0, 1, 0, 1, 0, 1};
    t2_addr = '{32'h2000, 32'h3000, 32'h2004, 32'h3004, 32'h2008, 32'h3008};
    t2_data = '{32'hFFFF2000, 32'hFFFF3000, 32'hFFFF2004, 32'hFFFF3004, 32'hFFFF2008, 32'hFFFF3008};
    t2_resp = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10};
`else
    t2_idx  = '{0, 0, 0, 1, 1, 1};
    t2_addr = '{32'h2000, 32'h2004, 32'h2008, 32'h3000, 32'h3004, 32'h3008};
    t2_data = '{32'hFFFF2000, 32'hFFFF2004, 32'hFFFF2008, 32'hFFFF3000, 32'hFFFF3004, 32'hFFFF3008};
    t2_resp = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_s_araddr", 64'(s_araddr), 64'd0);
    chk("rst_m_arready", 64'(m_arready), 64'd0);
    chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_s_rready", 64'(s_rready), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single read from master 1, response three cycles after the address
    r_delay = 3;
    push_g(1, 32'h1000);
    push_r(1, 32'hDEAD_BEEF, 2'b00);
    mq1.push_back(32'h1000);
    wait_done("t1_single_timeout");

    // Both masters requesting continuously
    r_delay = 1;
    for (int i = 0; i < 6; i++) begin
      push_g(t2_idx[i], t2_addr[i]);
      push_r(t2_idx[i], t2_data[i], t2_resp[i]);
    end
    mq0.push_back(32'h2000); mq0.push_back(32'h2004); mq0.push_back(32'h2008);
    mq1.push_back(32'h3000); mq1.push_back(32'h3004); mq1.push_back(32'h3008);
    wait_done("t2_contend_timeout");

    // Slave address backpressure for five cycles
    ar_delay = 5; r_delay = 0;
    push_g(0, 32'h2010);
    push_r(0, 32'hFFFF2010, 2'b00);
    mq0.push_back(32'h2010);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!s_arvalid && n < 50) begin @(negedge clk); n++; end
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_s_arvalid", 64'(s_arvalid), 64'd1);
      chk("bp_s_araddr", 64'(s_araddr), 64'h2010);
      if (k > 0) chk("bp_m_arready", 64'(m_arready), 64'd0);
      @(negedge clk);
    end
    wait_done("t3_backpressure_timeout");
    ar_delay = 0;

    // Master 1 stalls the response for four cycles
    m_rready = 2'b01;
    push_g(1, 32'h300C);
    push_r(1, 32'hFFFF300C, 2'b11);
    mq1.push_back(32'h300C);
    wait_rv(1, "t4_rvalid_timeout");
    for (int k = 0; k < 4; k++) begin
      chk("stall_s_rready", 64'(s_rready), 64'd0);
      chk("stall_m_rvalid", 64'(m_rvalid), 64'h2);
      if (k < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    m_rready = 2'b11;
    wait_done("t4_stall_timeout");
    @(negedge clk);
    chk("post_stall_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("post_stall_s_rready", 64'(s_rready), 64'd0);

    // Asynchronous reset while a stalled response is in DATA
    m_rready = 2'b01;
    push_g(1, 32'h3010);
    push_r(1, 32'hFFFF3010, 2'b00);
    mq1.push_back(32'h3010);
    wait_rv(1, "t5_rvalid_timeout");
    chk("pre_rst_m_rvalid", 64'(m_rvalid), 64'h2);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("mid_rst_s_rready", 64'(s_rready), 64'd0);
    chk("mid_rst_m_arready", 64'(m_arready), 64'd0);
    chk("mid_rst_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("mid_rst_s_araddr", 64'(s_araddr), 64'd0);
    g_q.delete();
    r_q.delete();
    m_rready = 2'b11;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Normal grant to master 1 after reset
    push_g(1, 32'h1000);
    push_r(1, 32'hDEAD_BEEF, 2'b00);
    mq1.push_back(32'h1000);
    wait_done("t6_after_reset_timeout");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares one AXI4-Lite read channel (AR + R) between `N_MASTERS` read requesters, such as instruction fetch and the core's load path, in front of the memory/MMU slave. It accepts one outstanding read at a time and forwards the address to the slave. It routes the response back to the granted master only, then re-arbitrates. Write channels bypass this block.

## Interface
Parameters:
- `N_MASTERS`, default 2: number of requesters; index 0 is highest fixed priority.
- `ADDR_W`, default 32: address width.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rstn` in 1: reset; **one clock; reset is asynchronous and active-low**.
- `m_araddr` in `N_MASTERS*ADDR_W`: per-master read address; master i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `m_arvalid` in `N_MASTERS`: per-master address valid.
- `m_arready` out `N_MASTERS`: per-master address accept; registered, one-hot or zero.
- `m_rdata` out 32: read data, broadcast to all masters.
- `m_rresp` out 2: read response, broadcast to all masters.
- `m_rvalid` out `N_MASTERS`: per-master data valid; only the granted bit can be 1.
- `m_rready` in `N_MASTERS`: per-master data ready.
- `s_araddr` out `ADDR_W`: slave read address; registered.
- `s_arvalid` out 1: slave address valid; registered.
- `s_arready` in 1: slave address ready.
- `s_rdata` in 32: slave read data.
- `s_rresp` in 2: slave read response.
- `s_rvalid` in 1: slave data valid.
- `s_rready` out 1: slave data ready.

## Operation
- The FSM has three states: `IDLE`, `ADDR`, `DATA`. Internal state is `grant` (index) and `last` (index of the last completed master).
- **IDLE**, any `m_arvalid` set:
  - Select the winner `g`.
  - At the clock edge: `grant<=g`, `s_araddr<=m_araddr[g]`, `s_arvalid<=1`, `m_arready[g]<=1`, go to `ADDR`.
  - With no request, stay in `IDLE`.
- **ADDR**:
  - `m_arready` is cleared after one cycle, so it is a single-cycle pulse.
  - On `s_arready` at the edge: `s_arvalid<=0`, go to `DATA`.
  - `s_araddr` is held stable while `s_arvalid` is high.
- **DATA**:
  - Combinational routing: `s_rready = m_rready[grant]`, `m_rvalid[grant] = s_rvalid`, all other `m_rvalid` bits are 0.
  - On `s_rvalid && s_rready`: `last<=grant`, go to `IDLE`.
- Outside `DATA`: `s_rready=0` and `m_rvalid=0`. An `s_rvalid` that arrives early is not forwarded.
- `m_rdata`/`m_rresp` are `s_rdata`/`s_rresp` passed straight through. They are meaningful only where `m_rvalid` is set.
- Arbitration uses fixed priority (lowest index wins) unless round-robin is compiled in (see Configuration).
- An `m_arvalid` that drops before its grant is simply not seen; no state is kept for it.

## Timing
- Reset values: state `IDLE`, `grant=0`, `last=N_MASTERS-1`, `s_araddr=0`, `s_arvalid=0`, `m_arready=0`. `s_rready` and `m_rvalid` are 0 as a consequence of the `IDLE` state.
- Best-case latency:
  - Request first seen at cycle 0.
  - `s_arvalid` and `m_arready[g]` are high in cycle 1.
  - `s_arready` in cycle 1 moves the FSM to `DATA` in cycle 2.
  - `s_rvalid` in cycle 2 passes through to `m_rvalid` in the same cycle.
- Response-side handshakes are combinational: no added latency and no buffering.
- Back-to-back requests always have at least one `IDLE` cycle between a response completing and the next `s_arvalid`. No same-cycle re-grant.
- If `s_arready` is already high in `IDLE`, it is ignored, because `s_arvalid` is still 0.
- `rstn` asserted mid-transaction drops the FSM to `IDLE` and clears all registered outputs. The in-flight slave read is abandoned, and the slave is reset by the same `rstn`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - The winner is the first requesting index found searching from `(last+1) mod N_MASTERS` upward with wrap.
  - After reset, `last=N_MASTERS-1`, so master 0 is searched first.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, lowest asserted index wins. `last` is still updated but unused.

## Test plan
- Single read: master 1 requests `0x0000_1000`, slave asserts `arready` at once and returns `rdata=0xDEADBEEF` 3 cycles later → `s_araddr=0x1000`, `m_arready=2'b10` for exactly one cycle, `m_rvalid=2'b10` with `m_rdata=0xDEADBEEF`, and `m_rvalid[0]` never set.
- Simultaneous requests, fixed priority: both masters request continuously for 3 transactions → grants go 0, 0, 0. With `ARB_ROUND_ROBIN_EN`, grants go 0, 1, 0.
- Slave backpressure: `s_arready` held low for 5 cycles → `s_arvalid` stays high and `s_araddr` stays stable throughout; `m_arready` pulses only once.
- Response stall: granted master holds `m_rready=0` for 4 cycles while `s_rvalid=1` → `s_rready=0`, the FSM stays in `DATA`, and it completes on the cycle `m_rready` rises.
- Reset mid-`DATA`: assert `rstn=0` asynchronously between clock edges → `s_arvalid`, `s_rready`, `m_arready` and `m_rvalid` go 0 immediately. After release, a new master 1 request is granted normally.
